// File: rtl/service_window_pkg.sv
// Shared types and constants for the service-window arbiter.
package service_window_pkg;

   localparam int SWLEN_W      = 8;
   localparam int DEFAULT_NREQ = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OPEN = 2'd1,
      S_GAP  = 2'd2
   } sw_state_e;

endpackage

// File: rtl/sw_rr_pick.sv
// Combinational round-robin picker: first requester after i_last (wrapping) wins.
module sw_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_last,
   output logic [NREQ-1:0] o_win_oh,
   output logic [IDW-1:0]  o_win_idx
);

   always_comb begin
      int          w_idx;
      logic        w_found;
      logic [NREQ-1:0] w_shift;
      o_win_oh  = '0;
      o_win_idx = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      w_shift   = '0;
      // Scan offsets 1..NREQ so the previous winner is considered last.
      for (int off = 1; off <= NREQ; off++) begin
         w_idx   = (int'(i_last) + off) % NREQ;
         w_shift = i_req >> w_idx;
         if (!w_found && w_shift[0]) begin
            w_found   = 1'b1;
            o_win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << w_idx;
            o_win_idx = w_idx[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/service_window_arbiter.sv
// Service-window arbiter: round-robin grants of fixed-length windows separated by a GAP+IDLE.
// Optional: define SWA_EARLY_RELEASE_EN to let the holder close its window early via i_done.
module service_window_arbiter
   import service_window_pkg::*;
#(
   parameter int NREQ = DEFAULT_NREQ,
   parameter int IDW  = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NREQ-1:0]    i_req,
   input  logic [NREQ-1:0]    i_done,
   input  logic [SWLEN_W-1:0] i_swlen,
   output logic [NREQ-1:0]    o_gnt,
   output logic [IDW-1:0]     o_gnt_id,
   output logic               o_swstat,
   output logic               o_expired,
   output logic [SWLEN_W-1:0] o_win_cnt
);

   sw_state_e          r_state, w_state_nxt;
   logic [NREQ-1:0]    r_gnt, w_gnt_nxt;
   logic [IDW-1:0]     r_gnt_id, w_gnt_id_nxt;
   logic [IDW-1:0]     r_last, w_last_nxt;
   logic               r_swstat, w_swstat_nxt;
   logic               r_expired, w_expired_nxt;
   logic [SWLEN_W-1:0] r_win_cnt, w_win_cnt_nxt;
   logic [NREQ-1:0]    w_pick_oh;
   logic [IDW-1:0]     w_pick_idx;
   logic [SWLEN_W-1:0] w_load;
   logic               w_release;

   sw_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .i_req     (i_req),
      .i_last    (r_last),
      .o_win_oh  (w_pick_oh),
      .o_win_idx (w_pick_idx)
   );

`ifdef SWA_EARLY_RELEASE_EN
   assign w_release = |(i_done & r_gnt);
`else
   logic w_unused_done;
   assign w_unused_done = ^i_done;
   assign w_release     = 1'b0;
`endif

   // A zero length still yields a one-cycle window so the counter never wraps.
   assign w_load = (i_swlen == '0) ? SWLEN_W'(1) : i_swlen;

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_id_nxt  = r_gnt_id;
      w_last_nxt    = r_last;
      w_swstat_nxt  = r_swstat;
      w_expired_nxt = 1'b0;
      w_win_cnt_nxt = r_win_cnt;
      case (r_state)
         S_IDLE: begin
            if (|i_req) begin
               w_state_nxt   = S_OPEN;
               w_gnt_nxt     = w_pick_oh;
               w_gnt_id_nxt  = w_pick_idx;
               w_last_nxt    = w_pick_idx;
               w_swstat_nxt  = 1'b0;
               w_win_cnt_nxt = w_load;
            end else begin
               w_gnt_nxt     = '0;
               w_swstat_nxt  = 1'b1;
               w_win_cnt_nxt = '0;
            end
         end
         S_OPEN: begin
            if (w_release || (r_win_cnt == SWLEN_W'(1))) begin
               w_state_nxt   = S_GAP;
               w_gnt_nxt     = '0;
               w_swstat_nxt  = 1'b1;
               w_win_cnt_nxt = '0;
               w_expired_nxt = ~w_release;
            end else begin
               w_win_cnt_nxt = r_win_cnt - SWLEN_W'(1);
            end
         end
         S_GAP: begin
            w_state_nxt   = S_IDLE;
            w_gnt_nxt     = '0;
            w_swstat_nxt  = 1'b1;
            w_win_cnt_nxt = '0;
         end
         default: begin
            w_state_nxt   = S_IDLE;
            w_gnt_nxt     = '0;
            w_swstat_nxt  = 1'b1;
            w_win_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_gnt     <= '0;
         r_gnt_id  <= '0;
         r_last    <= IDW'(NREQ - 1);
         r_swstat  <= 1'b1;
         r_expired <= 1'b0;
         r_win_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_gnt_id  <= w_gnt_id_nxt;
         r_last    <= w_last_nxt;
         r_swstat  <= w_swstat_nxt;
         r_expired <= w_expired_nxt;
         r_win_cnt <= w_win_cnt_nxt;
      end
   end

   assign o_gnt     = r_gnt;
   assign o_gnt_id  = r_gnt_id;
   assign o_swstat  = r_swstat;
   assign o_expired = r_expired;
   assign o_win_cnt = r_win_cnt;

endmodule

// File: tb/tb_service_window_arbiter.sv
// Scoreboard bench: stimulus queues expected windows, a negedge monitor checks each observed window.
module tb_service_window_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] done = '0;
   logic [7:0] swlen = '0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       swstat;
   logic       expired;
   logic [7:0] win_cnt;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] id;
      int         ld;
      int         len;
      bit         expd;
      bit         rst_abort;
      int         gap;
   } win_t;

   win_t exp_q[$];
   win_t cur;
   bit   in_win = 0;
   int   cnt = 0;
   int   closed = 99;
   int   n_chk = 0;
   int   n_fail = 0;

   service_window_arbiter #(.NREQ(4), .IDW(2)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req     (req),
      .i_done    (done),
      .i_swlen   (swlen),
      .o_gnt     (gnt),
      .o_gnt_id  (gnt_id),
      .o_swstat  (swstat),
      .o_expired (expired),
      .o_win_cnt (win_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [3:0] g, input logic [1:0] id, input int ld, input int len,
                       input bit expd, input bit ra, input int gap);
      win_t w;
      w.gnt = g; w.id = id; w.ld = ld; w.len = len;
      w.expd = expd; w.rst_abort = ra; w.gap = gap;
      exp_q.push_back(w);
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         if (in_win) begin
            in_win = 0;
            chk("win_len_at_reset", cnt, cur.len);
            if (!cur.rst_abort) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_reset_close: window id %0d closed by reset", cur.id);
            end
         end
         chk("rst_gnt", gnt, 0);
         chk("rst_gnt_id", gnt_id, 0);
         chk("rst_swstat", swstat, 1);
         chk("rst_expired", expired, 0);
         chk("rst_win_cnt", win_cnt, 0);
         closed = 99;
      end else begin
         chk("gnt_onehot0", int'($countones(gnt) <= 1), 1);
         chk("swstat_vs_gnt", swstat, ~|gnt);
         if (gnt != 0) begin
            if (!in_win) begin
               if (exp_q.size() == 0) begin
                  n_chk++; n_fail++;
                  $display("FAIL unexpected_grant: gnt %b id %0d with nothing expected", gnt, gnt_id);
                  cur.gnt = gnt; cur.id = gnt_id; cur.ld = win_cnt; cur.len = 0;
                  cur.expd = 0; cur.rst_abort = 0; cur.gap = -1;
               end else begin
                  cur = exp_q.pop_front();
                  chk("grant_id", gnt_id, cur.id);
                  if (cur.gap >= 0) chk("closed_gap", closed, cur.gap);
               end
               in_win = 1;
               cnt = 0;
            end
            chk("gnt_hold", gnt, cur.gnt);
            chk("win_cnt_open", win_cnt, cur.ld - cnt);
            chk("expired_open", expired, 0);
            cnt++;
         end else begin
            chk("win_cnt_closed", win_cnt, 0);
            if (in_win) begin
               in_win = 0;
               chk("win_len", cnt, cur.len);
               chk("expired_close", expired, cur.expd);
               if (cur.rst_abort) begin
                  n_chk++; n_fail++;
                  $display("FAIL missing_reset_close: window id %0d closed normally", cur.id);
               end
               closed = 1;
            end else begin
               chk("expired_idle", expired, 0);
               if (closed < 99) closed++;
            end
         end
      end
   end

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Four requesters held: strict rotation 0,1,2,3,0 with two closed cycles between.
      push(4'b0001, 2'd0, 2, 2, 1, 0, -1);
      push(4'b0010, 2'd1, 2, 2, 1, 0, 2);
      push(4'b0100, 2'd2, 2, 2, 1, 0, 2);
      push(4'b1000, 2'd3, 2, 2, 1, 0, 2);
      push(4'b0001, 2'd0, 2, 2, 1, 0, 2);
      swlen = 8'd2;
      req   = 4'b1111;
      tick(17);
      req = '0;
      tick(8);

      // Single requester, three-cycle window ending by timeout.
      push(4'b0001, 2'd0, 3, 3, 1, 0, -1);
      swlen = 8'd3;
      req   = 4'b0001;
      tick(1);
      req = '0;
      tick(8);

      // Zero length gives a single-cycle window.
      push(4'b0100, 2'd2, 1, 1, 1, 0, -1);
      swlen = 8'd0;
      req   = 4'b0100;
      tick(1);
      req = '0;
      tick(6);

      // Length change and holder dropping request mid-window do not shorten it.
      push(4'b1000, 2'd3, 5, 5, 1, 0, -1);
      swlen = 8'd5;
      req   = 4'b1000;
      tick(1);
      swlen = 8'd9;
      req   = '0;
      tick(10);

      // Early release by the holder; a non-holder strobe first.
`ifdef SWA_EARLY_RELEASE_EN
      push(4'b0010, 2'd1, 10, 3, 0, 0, -1);
`else
      push(4'b0010, 2'd1, 10, 10, 1, 0, -1);
`endif
      swlen = 8'd10;
      req   = 4'b0010;
      tick(1);
      req  = '0;
      tick(1);
      done = 4'b0001;
      tick(1);
      done = 4'b0010;
      tick(1);
      done = '0;
      tick(12);

      // Reset during the second open cycle, then requester 0 must win first.
      push(4'b0100, 2'd2, 5, 1, 0, 1, -1);
      swlen = 8'd5;
      req   = 4'b0100;
      tick(1);
      req = '0;
      tick(1);
      rst_n = 1'b0;
      tick(2);
      push(4'b0001, 2'd0, 1, 1, 1, 0, -1);
      rst_n = 1'b1;
      req   = 4'b1111;
      swlen = 8'd1;
      tick(1);
      req = '0;
      tick(6);

      chk("pending_windows", exp_q.size(), 0);
      chk("window_left_open", int'(in_win), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
